// File: rtl/bus_arb.sv
// bus_arb: two-master round-robin arbiter for the shared core bus.
// Grants one whole transaction at a time and returns a one-cycle
// acknowledge to the winning master. All outputs are registered.
// Optional watchdog: define BUS_ARB_TIMEOUT_EN to abort transactions the
// slave never completes after TIMEOUT_CYCLES bus-wait cycles.
module bus_arb #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  // master 0 (CPU core bus port)
  input  logic        m0_rd,
  input  logic        m0_wr,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wrmask,
  output logic        m0_ack,
  output logic        m0_err,
  output logic [31:0] m0_rdata,
  // master 1 (debug/DMA port)
  input  logic        m1_rd,
  input  logic        m1_wr,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wrmask,
  output logic        m1_ack,
  output logic        m1_err,
  output logic [31:0] m1_rdata,
  // shared bus
  output logic        o_bus_rd,
  output logic        o_bus_wr,
  output logic [31:0] o_bus_addr,
  output logic [3:0]  o_bus_wrmask,
  output logic [31:0] o_bus_data,
  input  logic        i_bus_rd_valid,
  input  logic        i_bus_wr_valid,
  input  logic [31:0] i_bus_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state;
  state_t      state_n;

  logic        rr_last;     // master granted most recently
  logic        grant;       // master owning the current transaction
  logic        is_wr;       // current transaction is a write

  logic        req0;
  logic        req1;
  logic        pick1;       // IDLE arbitration result: 1 selects master 1
  logic        start;       // grant issued this cycle
  logic        done_ok;     // matching completion seen in BUS
  logic        timeout;     // watchdog expired in BUS
  logic        finish;      // leave BUS this cycle

  logic        sel_wr;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic [3:0]  sel_wrmask;

  // Arbitration, request field selection and next-state decode
  always_comb begin
    req0       = m0_rd | m0_wr;
    req1       = m1_rd | m1_wr;
    // a lone requester wins; on a tie the master that did not go last wins
    pick1      = req1 & (~req0 | ~rr_last);
    // rd and wr together are treated as a write
    sel_wr     = pick1 ? m1_wr     : m0_wr;
    sel_addr   = pick1 ? m1_addr   : m0_addr;
    sel_wdata  = pick1 ? m1_wdata  : m0_wdata;
    sel_wrmask = pick1 ? m1_wrmask : m0_wrmask;

    state_n = state;
    start   = 1'b0;
    done_ok = 1'b0;
    finish  = 1'b0;
    case (state)
      IDLE: begin
        if (req0 | req1) begin
          start   = 1'b1;
          state_n = BUS;
        end
      end
      BUS: begin
        done_ok = is_wr ? i_bus_wr_valid : i_bus_rd_valid;
        if (done_ok || timeout) begin
          finish  = 1'b1;
          state_n = RESP;
        end
      end
      RESP: begin
        // requests are not examined here, so a held request cannot re-win
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

`ifdef BUS_ARB_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] wait_cnt;    // completed BUS cycles of the current transaction

  // Watchdog counter: cleared on grant, counts every BUS cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (start) begin
      wait_cnt <= '0;
    end else if (state == BUS) begin
      wait_cnt <= wait_cnt + 16'd1;
    end
  end

  // Expires during the TIMEOUT_CYCLES-th BUS cycle
  always_comb begin
    timeout = (state == BUS) && (wait_cnt == TO_LAST);
  end
`else
  assign timeout = 1'b0;
`endif

  // Grant bookkeeping, bus request registers and master responses
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_last      <= 1'b1;
      grant        <= 1'b0;
      is_wr        <= 1'b0;
      o_bus_rd     <= 1'b0;
      o_bus_wr     <= 1'b0;
      o_bus_addr   <= '0;
      o_bus_wrmask <= '0;
      o_bus_data   <= '0;
      m0_ack       <= 1'b0;
      m0_err       <= 1'b0;
      m0_rdata     <= '0;
      m1_ack       <= 1'b0;
      m1_err       <= 1'b0;
      m1_rdata     <= '0;
    end else begin
      m0_ack   <= 1'b0;
      m0_err   <= 1'b0;
      m0_rdata <= '0;
      m1_ack   <= 1'b0;
      m1_err   <= 1'b0;
      m1_rdata <= '0;

      if (start) begin
        grant        <= pick1;
        rr_last      <= pick1;
        is_wr        <= sel_wr;
        o_bus_rd     <= ~sel_wr;
        o_bus_wr     <= sel_wr;
        o_bus_addr   <= sel_addr;
        o_bus_wrmask <= sel_wrmask;
        o_bus_data   <= sel_wdata;
      end

      if (finish) begin
        o_bus_rd <= 1'b0;
        o_bus_wr <= 1'b0;
        // a completion in the expiry cycle takes priority over the abort
        if (grant) begin
          m1_ack   <= 1'b1;
          m1_err   <= ~done_ok;
          m1_rdata <= (done_ok && !is_wr) ? i_bus_data : '0;
        end else begin
          m0_ack   <= 1'b1;
          m0_err   <= ~done_ok;
          m0_rdata <= (done_ok && !is_wr) ? i_bus_data : '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_bus_arb.sv
// Directed self-checking bench for bus_arb. Cycle 0 is the cycle in which
// a request is first presented; outputs are sampled 1 time unit after each
// rising edge, and inputs are changed at the same point.
module tb_bus_arb;

  logic        clk;
  logic        rst;
  logic        m0_rd, m0_wr, m1_rd, m1_wr;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_wrmask, m1_wrmask;
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        o_bus_rd, o_bus_wr;
  logic [31:0] o_bus_addr, o_bus_data;
  logic [3:0]  o_bus_wrmask;
  logic        i_bus_rd_valid, i_bus_wr_valid;
  logic [31:0] i_bus_data;

  int unsigned n_cmp;
  int unsigned n_bad;

  bus_arb #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .m0_rd(m0_rd), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_wrmask(m0_wrmask), .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
    .m1_rd(m1_rd), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_wrmask(m1_wrmask), .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
    .o_bus_rd(o_bus_rd), .o_bus_wr(o_bus_wr), .o_bus_addr(o_bus_addr),
    .o_bus_wrmask(o_bus_wrmask), .o_bus_data(o_bus_data),
    .i_bus_rd_valid(i_bus_rd_valid), .i_bus_wr_valid(i_bus_wr_valid),
    .i_bus_data(i_bus_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2ms;
    $display("FAIL global_timeout: simulation did not finish, required finish before 2ms");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    m0_rd = 0; m0_wr = 0; m1_rd = 0; m1_wr = 0;
    m0_addr = '0; m0_wdata = '0; m0_wrmask = '0;
    m1_addr = '0; m1_wdata = '0; m1_wrmask = '0;
    i_bus_rd_valid = 0; i_bus_wr_valid = 0; i_bus_data = '0;
  endtask

  task automatic test_reset();
    rst = 1;
    step();
    step();
    n_cmp++; if ({m0_ack, m0_err, m1_ack, m1_err} !== 4'b0000) begin n_bad++;
      $display("FAIL reset_ack_err: got %b required 0000", {m0_ack, m0_err, m1_ack, m1_err}); end
    n_cmp++; if ({m0_rdata, m1_rdata} !== 64'h0) begin n_bad++;
      $display("FAIL reset_rdata: got %h required 0", {m0_rdata, m1_rdata}); end
    n_cmp++; if ({o_bus_rd, o_bus_wr} !== 2'b00) begin n_bad++;
      $display("FAIL reset_bus_req: got %b required 00", {o_bus_rd, o_bus_wr}); end
    n_cmp++; if ({o_bus_addr, o_bus_wrmask, o_bus_data} !== 68'h0) begin n_bad++;
      $display("FAIL reset_bus_fields: got %h required 0", {o_bus_addr, o_bus_wrmask, o_bus_data}); end
    rst = 0;
  endtask

  task automatic test_read();
    m0_addr = 32'h100;
    m0_rd = 1;
    for (int c = 1; c <= 3; c++) begin
      step();
      n_cmp++; if ({o_bus_rd, o_bus_wr, m0_ack} !== 3'b100) begin n_bad++;
        $display("FAIL read_bus_c%0d: rd/wr/ack got %b required 100", c, {o_bus_rd, o_bus_wr, m0_ack}); end
      n_cmp++; if (o_bus_addr !== 32'h100) begin n_bad++;
        $display("FAIL read_addr_c%0d: got %h required 00000100", c, o_bus_addr); end
      if (c == 3) begin
        i_bus_rd_valid = 1;
        i_bus_data = 32'hDEADBEEF;
      end
    end
    step();
    n_cmp++; if ({o_bus_rd, m0_ack, m0_err, m1_ack} !== 4'b0100) begin n_bad++;
      $display("FAIL read_ack: rd/ack0/err0/ack1 got %b required 0100", {o_bus_rd, m0_ack, m0_err, m1_ack}); end
    n_cmp++; if (m0_rdata !== 32'hDEADBEEF) begin n_bad++;
      $display("FAIL read_rdata: got %h required deadbeef", m0_rdata); end
    i_bus_rd_valid = 0;
    i_bus_data = '0;
    m0_rd = 0;
    step();
    n_cmp++; if ({m0_ack, o_bus_rd} !== 2'b00) begin n_bad++;
      $display("FAIL read_single_ack: ack0/rd got %b required 00", {m0_ack, o_bus_rd}); end
    step();
  endtask

  task automatic test_tie();
    rst = 1;
    step();
    rst = 0;
    m0_wr = 1; m0_addr = 32'hA0; m0_wdata = 32'h11; m0_wrmask = 4'hF;
    m1_rd = 1; m1_addr = 32'hB0;
    step();
    n_cmp++; if ({o_bus_rd, o_bus_wr} !== 2'b01 || o_bus_addr !== 32'hA0) begin n_bad++;
      $display("FAIL tie_first_grant: rd/wr %b addr %h required 01 000000a0", {o_bus_rd, o_bus_wr}, o_bus_addr); end
    i_bus_wr_valid = 1;
    step();
    n_cmp++; if ({m0_ack, m1_ack, o_bus_wr} !== 3'b100) begin n_bad++;
      $display("FAIL tie_m0_ack: ack0/ack1/wr got %b required 100", {m0_ack, m1_ack, o_bus_wr}); end
    i_bus_wr_valid = 0;
    m0_wr = 0;
    step();
    n_cmp++; if ({o_bus_rd, o_bus_wr} !== 2'b00) begin n_bad++;
      $display("FAIL tie_idle_gap: rd/wr got %b required 00", {o_bus_rd, o_bus_wr}); end
    step();
    n_cmp++; if (o_bus_rd !== 1'b1 || o_bus_addr !== 32'hB0) begin n_bad++;
      $display("FAIL tie_m1_start: rd %b addr %h required 1 000000b0", o_bus_rd, o_bus_addr); end
    i_bus_rd_valid = 1;
    i_bus_data = 32'hCAFE0001;
    step();
    n_cmp++; if ({m0_ack, m1_ack} !== 2'b01 || m1_rdata !== 32'hCAFE0001) begin n_bad++;
      $display("FAIL tie_m1_ack: ack0/ack1 %b rdata1 %h required 01 cafe0001", {m0_ack, m1_ack}, m1_rdata); end
    clear_inputs();
    step();
  endtask

  task automatic test_fairness();
    int unsigned who [8];
    int unsigned got;
    got = 0;
    m0_wr = 1; m0_addr = 32'h10;
    m1_wr = 1; m1_addr = 32'h20;
    i_bus_wr_valid = 1;
    for (int c = 0; c < 40 && got < 8; c++) begin
      step();
      if (m0_ack || m1_ack) begin
        who[got] = (m0_ack && m1_ack) ? 2 : (m1_ack ? 1 : 0);
        got++;
      end
    end
    clear_inputs();
    n_cmp++; if (got !== 8) begin n_bad++;
      $display("FAIL fair_count: acks within 40 cycles got %0d required 8", got); end
    for (int i = 0; i < 8; i++) begin
      if (i < int'(got)) begin
        n_cmp++; if (who[i] !== (i % 2)) begin n_bad++;
          $display("FAIL fair_grant_%0d: master got %0d required %0d", i, who[i], i % 2); end
      end
    end
    step();
    step();
  endtask

  task automatic test_wrmask();
    m1_wr = 1; m1_addr = 32'h2004; m1_wdata = 32'h12345678; m1_wrmask = 4'b0110;
    i_bus_data = 32'hFFFFFFFF;
    for (int c = 1; c <= 3; c++) begin
      step();
      n_cmp++; if ({o_bus_rd, o_bus_wr, m1_ack} !== 3'b010) begin n_bad++;
        $display("FAIL wm_req_c%0d: rd/wr/ack1 got %b required 010", c, {o_bus_rd, o_bus_wr, m1_ack}); end
      n_cmp++; if (o_bus_addr !== 32'h2004 || o_bus_data !== 32'h12345678 || o_bus_wrmask !== 4'b0110) begin n_bad++;
        $display("FAIL wm_fields_c%0d: got %h %h %b required 00002004 12345678 0110", c, o_bus_addr, o_bus_data, o_bus_wrmask); end
      // a changed wdata and a non-matching read valid must both be ignored
      i_bus_rd_valid = (c == 1);
      if (c == 1) m1_wdata = 32'hBAD0BAD0;
      i_bus_wr_valid = (c == 3);
    end
    step();
    n_cmp++; if ({m1_ack, m1_err, m0_ack, o_bus_wr} !== 4'b1000) begin n_bad++;
      $display("FAIL wm_ack: ack1/err1/ack0/wr got %b required 1000", {m1_ack, m1_err, m0_ack, o_bus_wr}); end
    n_cmp++; if (m1_rdata !== 32'h0) begin n_bad++;
      $display("FAIL wm_rdata: got %h required 0", m1_rdata); end
    n_cmp++; if (o_bus_addr !== 32'h2004) begin n_bad++;
      $display("FAIL wm_addr_hold: got %h required 00002004", o_bus_addr); end
    clear_inputs();
    step();
  endtask

  task automatic test_timeout();
`ifdef BUS_ARB_TIMEOUT_EN
    m0_rd = 1; m0_addr = 32'h300; i_bus_data = 32'h55AA55AA;
    for (int c = 1; c <= 4; c++) begin
      step();
      n_cmp++; if ({o_bus_rd, m0_ack} !== 2'b10) begin n_bad++;
        $display("FAIL to_wait_c%0d: rd/ack0 got %b required 10", c, {o_bus_rd, m0_ack}); end
    end
    step();
    n_cmp++; if ({o_bus_rd, m0_ack, m0_err} !== 3'b011 || m0_rdata !== 32'h0) begin n_bad++;
      $display("FAIL to_abort: rd/ack0/err0 %b rdata %h required 011 0", {o_bus_rd, m0_ack, m0_err}, m0_rdata); end
    m0_rd = 0;
    step();
    n_cmp++; if ({m0_ack, m0_err} !== 2'b00) begin n_bad++;
      $display("FAIL to_after: ack0/err0 got %b required 00", {m0_ack, m0_err}); end
    // completion in the expiry cycle wins over the abort
    m0_rd = 1; i_bus_data = 32'h600D600D;
    for (int c = 1; c <= 4; c++) begin
      step();
      if (c == 4) i_bus_rd_valid = 1;
    end
    step();
    n_cmp++; if ({m0_ack, m0_err} !== 2'b10 || m0_rdata !== 32'h600D600D) begin n_bad++;
      $display("FAIL to_race: ack0/err0 %b rdata %h required 10 600d600d", {m0_ack, m0_err}, m0_rdata); end
`else
    int unsigned bad_cycles;
    bad_cycles = 0;
    m0_rd = 1; m0_addr = 32'h300;
    for (int c = 0; c < 1000; c++) begin
      step();
      if (o_bus_rd !== 1'b1 || m0_ack !== 1'b0 || m0_err !== 1'b0) bad_cycles++;
    end
    n_cmp++; if (bad_cycles !== 0) begin n_bad++;
      $display("FAIL nowd_hold: cycles with dropped request or ack got %0d required 0", bad_cycles); end
    i_bus_rd_valid = 1; i_bus_data = 32'h600D600D;
    step();
    n_cmp++; if ({m0_ack, m0_err} !== 2'b10 || m0_rdata !== 32'h600D600D) begin n_bad++;
      $display("FAIL nowd_done: ack0/err0 %b rdata %h required 10 600d600d", {m0_ack, m0_err}, m0_rdata); end
`endif
    clear_inputs();
    step();
  endtask

  task automatic test_reset_mid();
    m0_rd = 1; m0_addr = 32'h400;
    step();
    n_cmp++; if (o_bus_rd !== 1'b1) begin n_bad++;
      $display("FAIL rmid_start: rd got %b required 1", o_bus_rd); end
    step();
    rst = 1;
    step();
    n_cmp++; if ({o_bus_rd, m0_ack} !== 2'b00) begin n_bad++;
      $display("FAIL rmid_drop: rd/ack0 got %b required 00", {o_bus_rd, m0_ack}); end
    rst = 0;
    m0_rd = 0;
    i_bus_rd_valid = 1;
    step();
    n_cmp++; if ({o_bus_rd, m0_ack} !== 2'b00) begin n_bad++;
      $display("FAIL rmid_no_ack: rd/ack0 got %b required 00", {o_bus_rd, m0_ack}); end
    i_bus_rd_valid = 0;
    m0_wr = 1; m0_addr = 32'hA4;
    m1_wr = 1; m1_addr = 32'hB4;
    step();
    n_cmp++; if (o_bus_wr !== 1'b1 || o_bus_addr !== 32'hA4) begin n_bad++;
      $display("FAIL rmid_tie: wr %b addr %h required 1 000000a4", o_bus_wr, o_bus_addr); end
    i_bus_wr_valid = 1;
    step();
    n_cmp++; if ({m0_ack, m1_ack} !== 2'b10) begin n_bad++;
      $display("FAIL rmid_tie_ack: ack0/ack1 got %b required 10", {m0_ack, m1_ack}); end
    clear_inputs();
    step();
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1;
    clear_inputs();
    test_reset();
    test_read();
    test_tie();
    test_fairness();
    test_wrmask();
    test_timeout();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bus_arb.md
# bus_arb

Two-master round-robin arbiter sharing the single core bus (rd/wr request, address, data, byte mask; rd-valid/wr-valid/data response) between master 0 (the CPU core's bus port) and master 1 (debug/DMA port). It sits between the masters and the memory/peripheral interconnect. It grants one whole transaction at a time and returns a one-cycle acknowledge to the winning master. An optional watchdog aborts transactions the slave never completes.

## Interface
- TIMEOUT_CYCLES, 255: bus-wait cycles before abort (only with watchdog compiled in); 1..65535.
- clk  in  1  clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- mN_rd  in  1  master N (N=0,1) read request; level, held until mN_ack.
- mN_wr  in  1  master N write request; level, held until mN_ack.
- mN_addr  in  32  master N byte address; stable while request held.
- mN_wdata  in  32  master N write data.
- mN_wrmask  in  4  master N byte-lane write mask.
- mN_ack  out  1  one-cycle completion pulse to master N.
- mN_err  out  1  with mN_ack: transaction aborted by watchdog.
- mN_rdata  out  32  read data, valid while mN_ack=1; 0 for writes/aborts.
- o_bus_rd  out  1  bus read request.
- o_bus_wr  out  1  bus write request.
- o_bus_addr  out  32  bus address.
- o_bus_wrmask  out  4  bus write mask.
- o_bus_data  out  32  bus write data.
- i_bus_rd_valid  in  1  read completion; i_bus_data valid this cycle.
- i_bus_wr_valid  in  1  write completion.
- i_bus_data  in  32  read data from bus.

## Operation
- States: IDLE, BUS, RESP. Reset -> IDLE.
- IDLE: requesting set = {N : mN_rd|mN_wr}. Empty -> stay. One -> grant it. Both -> grant master != rr_last. On grant: latch addr/wdata/wrmask/kind into bus registers, rr_last <= grantee, -> BUS.
- mN_rd and mN_wr both high: treated as write.
- BUS: o_bus_rd or o_bus_wr held high with latched fields. The completion matching the kind (i_bus_rd_valid for read, i_bus_wr_valid for write) -> drop request, register ack/rdata, -> RESP. A non-matching valid is ignored.
- RESP: mG_ack=1 for grantee G only; mG_rdata = captured i_bus_data for reads, 0 for writes. -> IDLE. The grantee's request is masked this cycle, so a still-held request is not re-granted.
- rr_last reset value 1, so master 0 wins the first tie.
- Valids arriving in IDLE or RESP are ignored.
- Reset values: all mN_ack/mN_err 0; mN_rdata 0; o_bus_rd/o_bus_wr 0; o_bus_addr/o_bus_wrmask/o_bus_data 0.
- Outside BUS: o_bus_rd/o_bus_wr are 0; addr/mask/data hold their last value.
- Reset mid-transaction: immediate return to IDLE, bus request dropped next edge, no ack issued, rr_last=1.

## Timing
- All outputs registered.
- Request sampled in IDLE at cycle 0 -> o_bus_rd/wr high from cycle 1.
- Completion at cycle 1+W (W>=0 slave wait) -> bus request low and mN_ack high at cycle 2+W -> IDLE at 3+W.
- Zero-wait transaction: 3 cycles. Back-to-back throughput: one transaction per 3+W cycles.
- Grant never changes while in BUS. Master request fields are not re-sampled after grant.

## Configuration
- BUS_ARB_TIMEOUT_EN defined:
  - 16-bit counter clears on entry to BUS and increments each BUS cycle.
  - If it reaches TIMEOUT_CYCLES with no matching valid: drop bus request, -> RESP with mG_ack=1, mG_err=1, mG_rdata=0.
  - A valid arriving in the same cycle as the timeout wins (normal completion).
- Undefined: no counter; BUS waits indefinitely; mN_err tied 0.

## Test plan
- Read, single master: m0_rd, addr 0x100; slave asserts i_bus_rd_valid with data 0xDEADBEEF two cycles after o_bus_rd -> o_bus_rd high cycles 1-3, m0_ack and m0_rdata=0xDEADBEEF at cycle 4, single ack.
- Tie: m0_wr and m1_rd asserted together from reset -> m0 granted first; m1 transaction starts the cycle after m0 returns to IDLE.
- Fairness: m0 and m1 request continuously, zero-wait slave -> grants alternate 0,1,0,1 over 8 transactions; neither master gets two consecutive grants.
- Write mask: m1_wr, addr 0x2004, data 0x12345678, mask 0b0110 -> bus outputs match exactly for the whole BUS interval; m1_rdata=0 with ack.
- Timeout (macro on, TIMEOUT_CYCLES=4): m0_rd, slave silent -> bus request drops after 4 BUS cycles; m0_ack=1, m0_err=1, m0_rdata=0. Macro off: request stays high for 1000 cycles, no ack.
- Reset mid-BUS: rst pulsed during m0 read wait -> o_bus_rd=0 after the edge, no m0_ack, next tie grants m0.
